// File: rtl/mem_bus_sequencer_if.sv
// rtl/mem_bus_sequencer_if.sv - requester and memory-pad signal bundle for the bus sequencer
interface mem_bus_sequencer_if #(
  parameter int W = 16
);
  logic         d_req;
  logic         d_wr;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         x_req;
  logic         x_wr;
  logic [W-1:0] x_addr;
  logic [W-1:0] x_wdata;
  logic [2:0]   ack;
  logic [W-1:0] rdata;
  logic         ale;
  logic         enb;
  logic         rw;
  logic [W-1:0] bus_out;
  logic         bus_oe;
  logic [W-1:0] bus_in;
  logic         busy;

  // Sequencer side: consumes requests and pad input, produces bus timing and responses.
  modport slave (
    input  d_req, d_wr, d_addr, d_wdata,
    input  i_req, i_addr,
    input  x_req, x_wr, x_addr, x_wdata,
    input  bus_in,
    output ack, rdata, ale, enb, rw, bus_out, bus_oe, busy
  );

  // Requester/pad side: drives requests and sampled bus value, observes the sequencer.
  modport master (
    output d_req, d_wr, d_addr, d_wdata,
    output i_req, i_addr,
    output x_req, x_wr, x_addr, x_wdata,
    output bus_in,
    input  ack, rdata, ale, enb, rw, bus_out, bus_oe, busy
  );
endinterface

// File: rtl/mem_bus_sequencer.sv
// rtl/mem_bus_sequencer.sv - round-robin arbiter and multiplexed address/data bus sequencer
module mem_bus_sequencer #(
  parameter int W           = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  mem_bus_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, XFER, RESP} state_t;

  // Counter is loaded in ADDR so WAIT lasts exactly WAIT_CYCLES cycles.
  localparam int         WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_LOAD = WAIT_M1[3:0];

  state_t       state;
  state_t       state_next;
  logic [1:0]   last;
  logic [1:0]   grant;
  logic [1:0]   pick;
  logic         pick_valid;
  logic [2:0]   req;
  logic [3:0]   cnt;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic         wr_q;
  logic [W-1:0] rdata_q;

  logic         ale;
  logic         enb;
  logic         rw;
  logic         bus_oe;
  logic [W-1:0] bus_out;
  logic [2:0]   ack;

  // Requester index: 0 = D, 1 = I, 2 = X.
  assign req = {bus.x_req, bus.i_req, bus.d_req};

  // Round-robin winner: search starts at the requester after the last one served.
  always_comb begin
    pick_valid = |req;
    pick       = 2'd0;
    case (last)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // State register; reset aborts any cycle in flight without acknowledging it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and bus-phase decode; every non-active phase falls back to idle bus values.
  always_comb begin
    state_next = state;
    ale        = 1'b0;
    enb        = 1'b0;
    rw         = 1'b1;
    bus_oe     = 1'b0;
    bus_out    = '0;
    ack        = 3'b000;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = ADDR;
      end
      ADDR: begin
        ale        = 1'b1;
        bus_oe     = 1'b1;
        bus_out    = addr_q;
        rw         = ~wr_q;
        state_next = (WAIT_CYCLES > 0) ? WAIT : XFER;
      end
      WAIT: begin
        bus_oe  = wr_q;
        bus_out = wr_q ? wdata_q : '0;
        rw      = ~wr_q;
        if (cnt == 4'd0) state_next = XFER;
      end
      XFER: begin
        enb        = ~wr_q;
        bus_oe     = wr_q;
        bus_out    = wr_q ? wdata_q : '0;
        rw         = ~wr_q;
        state_next = RESP;
      end
      RESP: begin
        ack        = 3'b001 << grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: latch the winner in IDLE, count wait states, capture read data, rotate priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= 2'd2;
      grant   <= 2'd0;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            case (pick)
              2'd0: begin
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                wr_q    <= bus.d_wr;
              end
              2'd1: begin
                addr_q  <= bus.i_addr;
                wdata_q <= '0;
                wr_q    <= 1'b0;
              end
              default: begin
                addr_q  <= bus.x_addr;
                wdata_q <= bus.x_wdata;
                wr_q    <= bus.x_wr;
              end
            endcase
          end
        end
        ADDR: cnt <= WAIT_LOAD;
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        XFER: if (!wr_q) rdata_q <= bus.bus_in;
        RESP: last <= grant;
        default: ;
      endcase
    end
  end

  assign bus.ale     = ale;
  assign bus.enb     = enb;
  assign bus.rw      = rw;
  assign bus.bus_oe  = bus_oe;
  assign bus.bus_out = bus_out;
  assign bus.ack     = ack;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: doc/mem_bus_sequencer.md
Name: mem_bus_sequencer

Overview:
- Sequences the processor's multiplexed external address/data bus.
- Arbitrates the bus between three requesters: data load/store (D), instruction fetch (I) and external host/debug port (X).
- Generates the Ale/Enb/Rw bus-cycle timing with a configurable number of wait states.
- Returns read data and a one-cycle acknowledge to the granted requester. Sits between the control unit/datapath and the memory pads.

Parameters:
- W, 16, width of address, data and the multiplexed bus.
- WAIT_CYCLES, 1, wait states inserted between address phase and data phase (0..15).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DReq  input  1  data requester wants a bus cycle.
- DWr  input  1  1 = write, 0 = read (D).
- DAddr  input  W  D address.
- DWData  input  W  D write data.
- IReq  input  1  instruction fetch request (read only).
- IAddr  input  W  fetch address.
- XReq  input  1  external requester wants a bus cycle.
- XWr  input  1  1 = write, 0 = read (X).
- XAddr  input  W  X address.
- XWData  input  W  X write data.
- Ack  output  3  one-cycle completion pulse; bit0 = D, bit1 = I, bit2 = X.
- RData  output  W  registered read data, valid in the Ack cycle.
- Ale  output  1  address latch enable.
- Enb  output  1  memory output enable (read data phase).
- Rw  output  1  1 = read cycle, 0 = write cycle.
- BusOut  output  W  value driven onto the multiplexed bus.
- BusOe  output  1  drive enable for BusOut pad buffers.
- BusIn  input  W  value sampled from the multiplexed bus.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate, also mid-cycle):
  - State = IDLE; Ack = 0, RData = 0, Ale = 0, Enb = 0, Rw = 1, BusOut = 0, BusOe = 0, Busy = 0.
  - Round-robin pointer Last = X, so D has first priority after reset.
  - Wait counter = 0.
  - An aborted transfer is never acknowledged.
- States: IDLE, ADDR, WAIT, XFER, RESP.
- IDLE:
  - If any Req is high, pick the winner round-robin starting after Last (order D, I, X).
  - Latch the winner's address, write data and Wr (I is always a read); register Grant; go to ADDR. Otherwise stay.
- ADDR (1 cycle):
  - Ale = 1, BusOe = 1, BusOut = latched address, Rw = ~Wr.
  - Next state is WAIT if WAIT_CYCLES > 0, else XFER. Load counter = WAIT_CYCLES - 1.
- WAIT:
  - Ale = 0; BusOe = Wr; BusOut = write data if write, else 0; Rw held.
  - Counter decrements; at 0 go to XFER.
- XFER (1 cycle):
  - Read: Enb = 1, BusOe = 0; RData <= BusIn on the edge ending XFER.
  - Write: BusOe = 1, BusOut = write data, Enb = 0.
  - Go to RESP.
- RESP (1 cycle):
  - Ack[Grant] = 1; Last <= Grant; bus outputs return to their idle values; go to IDLE.
  - For writes RData keeps its previous value.
- Latency: from the first IDLE cycle with Req high, Ack rises 3 + WAIT_CYCLES cycles later.
- Requester rules:
  - Hold Req, address, write data and Wr stable until Ack.
  - Deassert Req on the edge ending the Ack cycle.
  - Inputs that change after grant are ignored, because the values are latched in IDLE.
- Req dropped before grant: no cycle. Req dropped after grant: the cycle completes and is acknowledged.
- Simultaneous requests: exactly one grant per transaction. Round-robin guarantees each requester waits at most two other transactions.
- Ack is one-hot or zero; never more than one bit set.
- Rw must equal 1 in IDLE. Ale and Enb are never high together.

Test Plan:
- Reset mid-XFER of a D read → outputs idle next sample, no Ack; then DReq read 0x1234, WAIT_CYCLES = 1 → Ale in cycle 1, Enb in cycle 3, Ack = 001 in cycle 4, RData = BusIn value 0xBEEF.
- DReq write addr 0x0040 data 0x5A5A → ADDR: BusOut = 0x0040, Rw = 0, Ale = 1; WAIT/XFER: BusOut = 0x5A5A, BusOe = 1, Enb = 0; Ack = 001; RData unchanged.
- DReq, IReq, XReq held continuously from reset → grants in order D, I, X, D, I, X; Ack sequence 001, 010, 100, 001.
- WAIT_CYCLES = 0, IReq read 0x0100 → ADDR, XFER, RESP; Ack = 010 exactly 3 cycles after request; WAIT state never entered.
- WAIT_CYCLES = 3, XReq read → Enb asserted only in the single XFER cycle, 4 cycles after Ale; Busy high from ADDR through RESP.
- DReq pulsed for 1 cycle while a transfer for I is busy → no D cycle, no Ack[0]; DAddr changed after grant → ADDR phase still shows the latched address.
